// File: rtl/stopwatch_core_if.sv
// Button, tick and display bundle between the stopwatch core and its surroundings.
// The master side drives controls and reads the display; the core is the slave.
interface stopwatch_core_if;
  logic        ena;
  logic        tick_in;
  logic        btn_ss;
  logic        btn_lap;
  logic        btn_clr;
  logic [23:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output ena, tick_in, btn_ss, btn_lap, btn_clr,
    input  disp_bcd, running, lap_active, overflow
  );

  modport slave (
    input  ena, tick_in, btn_ss, btn_lap, btn_clr,
    output disp_bcd, running, lap_active, overflow
  );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS:CC BCD stopwatch counting rising edges of a 100 Hz tick, with start/stop,
// lap freeze and clear driven by synchronised, edge-detected button inputs.
module stopwatch_core #(
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_MIN    = 60
) (
  input  logic            clk_in,
  input  logic            res,
  stopwatch_core_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam int         MIN_LAST     = WRAP_MIN - 1;
  localparam logic [7:0] MIN_LAST_BCD = {4'(MIN_LAST / 10), 4'(MIN_LAST % 10)};

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;

  assign btn_raw = {bus.btn_clr, bus.btn_lap, bus.btn_ss};

  // Sync chains and edge detectors keep sampling while ena is low, so edges seen then are lost.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in) begin
      if (res) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign btn_pulse[gi] = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  logic        ss_p, lap_p, clr_p;
  logic        tick_q, tick_rise;
  logic [1:0]  state_q, state_d;
  logic [23:0] time_q, time_d, time_inc;
  logic [23:0] hold_q, hold_d;
  logic [23:0] disp_q, disp_d;
  logic        lap_q, lap_d;
  logic        ovf_q, ovf_d;
  logic        wrap;

  assign ss_p      = btn_pulse[BTN_SS];
  assign lap_p     = btn_pulse[BTN_LAP];
  assign clr_p     = btn_pulse[BTN_CLR];
  assign tick_rise = bus.tick_in & ~tick_q;

  // Ripple BCD increment; time layout is {min_t, min_o, sec_t, sec_o, cs_t, cs_o}.
  always_comb begin
    time_inc = time_q;
    wrap     = 1'b0;
    if (time_q[3:0] != 4'd9) begin
      time_inc[3:0] = time_q[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_q[7:4] != 4'd9) begin
        time_inc[7:4] = time_q[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_q[11:8] != 4'd9) begin
          time_inc[11:8] = time_q[11:8] + 4'd1;
        end else begin
          time_inc[11:8] = 4'd0;
          if (time_q[15:12] != 4'd5) begin
            time_inc[15:12] = time_q[15:12] + 4'd1;
          end else begin
            time_inc[15:12] = 4'd0;
            if (time_q[23:16] == MIN_LAST_BCD) begin
              time_inc[23:16] = 8'd0;
              wrap            = 1'b1;
            end else if (time_q[19:16] != 4'd9) begin
              time_inc[19:16] = time_q[19:16] + 4'd1;
            end else begin
              time_inc[19:16] = 4'd0;
              time_inc[23:20] = time_q[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Tick is applied first, then one button action with priority ss > clr > lap.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    hold_d  = hold_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;
    if (bus.ena) begin
      if ((state_q == RUN) && tick_rise) begin
        time_d = time_inc;
        if (wrap) begin
          ovf_d = 1'b1;
        end
      end
      if (ss_p) begin
        state_d = (state_q == RUN) ? STOP : RUN;
      end else if (clr_p) begin
        if (state_q == STOP) begin
          state_d = IDLE;
          time_d  = '0;
          ovf_d   = 1'b0;
          lap_d   = 1'b0;
        end
      end else if (lap_p) begin
        if (state_q == RUN) begin
          lap_d = ~lap_q;
          if (!lap_q) begin
            hold_d = time_q;
          end
        end else if (state_q == STOP) begin
          lap_d = 1'b0;
        end
      end
    end
    disp_d = lap_d ? hold_d : time_d;
  end

  always_ff @(posedge clk_in) begin
    if (res) begin
      state_q <= IDLE;
      time_q  <= '0;
      hold_q  <= '0;
      disp_q  <= '0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      tick_q  <= bus.tick_in;
    end
  end

  assign bus.disp_bcd   = disp_q;
  assign bus.running    = (state_q == RUN);
  assign bus.lap_active = lap_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Stopwatch core bench: directed scenarios plus random stimulus, every cycle compared
// against a centisecond-count reference model.
`timescale 1ns/1ps
module tb_stopwatch_core;
  localparam int S       = 3;
  localparam int WRAP    = 2;
  localparam int WRAP_CS = WRAP * 6000;

  logic clk_in = 1'b0;
  logic res;
  stopwatch_core_if bus ();

  stopwatch_core #(.SYNC_STAGES(S), .WRAP_MIN(WRAP)) dut (
    .clk_in (clk_in),
    .res    (res),
    .bus    (bus)
  );

  always #500 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_t;
  mstate_t m_state;
  int      m_cs;
  int      m_hold;
  bit      m_lap;
  bit      m_ovf;
  bit      m_tick_prev;
  bit      m_hist [3][S+1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  // Button action at an edge comes from the raw level S and S+1 edges earlier.
  task automatic model_step();
    bit raw [3];
    bit p [3];
    bit rise;
    int old;
    raw[0] = bus.btn_ss;
    raw[1] = bus.btn_lap;
    raw[2] = bus.btn_clr;
    if (res) begin
      m_state = M_IDLE;
      m_cs = 0; m_hold = 0; m_lap = 0; m_ovf = 0; m_tick_prev = 0;
      foreach (m_hist[b, i]) m_hist[b][i] = 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) p[b] = m_hist[b][S-1] & ~m_hist[b][S];
      rise = bus.tick_in & ~m_tick_prev;
      if (bus.ena) begin
        old = m_cs;
        if (m_state == M_RUN && rise) begin
          m_cs++;
          if (m_cs == WRAP_CS) begin
            m_cs  = 0;
            m_ovf = 1'b1;
          end
        end
        if (p[0]) begin
          if (m_state == M_RUN) m_state = M_STOP;
          else m_state = M_RUN;
        end else if (p[2]) begin
          if (m_state == M_STOP) begin
            m_state = M_IDLE; m_cs = 0; m_ovf = 0; m_lap = 0;
          end
        end else if (p[1]) begin
          if (m_state == M_RUN) begin
            if (!m_lap) begin
              m_hold = old;
              m_lap  = 1'b1;
            end else begin
              m_lap = 1'b0;
            end
          end else if (m_state == M_STOP) begin
            m_lap = 1'b0;
          end
        end
      end
      for (int b = 0; b < 3; b++) begin
        for (int i = S; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = raw[b];
      end
      m_tick_prev = bus.tick_in;
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    check_val("model_disp", bus.disp_bcd, m_lap ? to_bcd(m_hold) : to_bcd(m_cs));
    check_val("model_running", bus.running, m_state == M_RUN);
    check_val("model_lap", bus.lap_active, m_lap);
    check_val("model_ovf", bus.overflow, m_ovf);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_in = 1'b1; cycle();
      bus.tick_in = 1'b0; cycle();
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_ss  = v;
      1: bus.btn_lap = v;
      default: bus.btn_clr = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); cycles(S + 2);
    set_btn(b, 1'b0); cycles(S + 2);
  endtask

  task automatic do_reset();
    res = 1'b1; cycle(); res = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    bus.ena = 1'b1; bus.tick_in = 1'b0;
    bus.btn_ss = 1'b0; bus.btn_lap = 1'b0; bus.btn_clr = 1'b0;
    cycles(2);
    check_val("rst_disp", bus.disp_bcd, 24'h0);
    check_val("rst_running", bus.running, 1'b0);
    check_val("rst_lap", bus.lap_active, 1'b0);
    check_val("rst_ovf", bus.overflow, 1'b0);
    res = 1'b0;
    $display("txn reset: disp=%h", bus.disp_bcd);

    // start latency: action lands on the (S+1)th edge after the press
    bus.btn_ss = 1'b1; cycles(S);
    check_val("ss_latency_early", bus.running, 1'b0);
    cycle();
    check_val("ss_latency", bus.running, 1'b1);
    bus.btn_ss = 1'b0; cycles(S + 2);
    tick(100);
    check_val("t1_disp", bus.disp_bcd, 24'h000100);
    check_val("t1_running", bus.running, 1'b1);
    $display("txn 100 ticks: disp=%h", bus.disp_bcd);

    tick(WRAP_CS - 1 - m_cs);
    check_val("t2_last", bus.disp_bcd, 24'h015999);
    tick(1);
    check_val("t2_wrap_disp", bus.disp_bcd, 24'h0);
    check_val("t2_wrap_ovf", bus.overflow, 1'b1);
    tick(3);
    check_val("t2_after_wrap", bus.disp_bcd, 24'h000003);
    press(0); press(2);
    check_val("t2_clr_ovf", bus.overflow, 1'b0);
    check_val("t2_clr_running", bus.running, 1'b0);
    check_val("t2_clr_disp", bus.disp_bcd, 24'h0);
    $display("txn wrap and clear: disp=%h ovf=%0b", bus.disp_bcd, bus.overflow);

    press(0); tick(1234);
    check_val("t3_live", bus.disp_bcd, 24'h001234);
    press(1);
    check_val("t3_lap_on", bus.lap_active, 1'b1);
    tick(50);
    check_val("t3_frozen", bus.disp_bcd, 24'h001234);
    press(1);
    check_val("t3_lap_off", bus.lap_active, 1'b0);
    check_val("t3_resume", bus.disp_bcd, 24'h001284);
    $display("txn lap freeze/unfreeze: disp=%h", bus.disp_bcd);

    bus.btn_lap = 1'b1; cycles(S);
    bus.tick_in = 1'b1; cycle(); bus.tick_in = 1'b0;
    check_val("lap_tick_frozen", bus.disp_bcd, 24'h001284);
    cycles(2); bus.btn_lap = 1'b0; cycles(S + 2);
    press(1);
    check_val("lap_tick_live", bus.disp_bcd, 24'h001285);
    bus.btn_ss = 1'b1; cycles(S);
    bus.tick_in = 1'b1; cycle(); bus.tick_in = 1'b0;
    check_val("ss_tick_running", bus.running, 1'b0);
    check_val("ss_tick_disp", bus.disp_bcd, 24'h001286);
    bus.btn_ss = 1'b0; cycles(S + 2);
    $display("txn same-cycle lap/ss with tick: disp=%h", bus.disp_bcd);

    do_reset(); press(0); tick(500); press(0);
    check_val("t4_stopped", bus.running, 1'b0);
    bus.btn_ss = 1'b1; bus.btn_clr = 1'b1; cycles(S + 2);
    bus.btn_ss = 1'b0; bus.btn_clr = 1'b0; cycles(S + 2);
    check_val("t4_running", bus.running, 1'b1);
    check_val("t4_disp", bus.disp_bcd, 24'h000500);
    $display("txn ss+clr in STOP: disp=%h running=%0b", bus.disp_bcd, bus.running);

    do_reset(); press(0); tick(37);
    check_val("t5_pre", bus.disp_bcd, 24'h000037);
    res = 1'b1; bus.tick_in = 1'b1; cycle();
    check_val("t5_rst_disp", bus.disp_bcd, 24'h0);
    check_val("t5_rst_running", bus.running, 1'b0);
    res = 1'b0; bus.tick_in = 1'b0; cycle();
    tick(1);
    check_val("t5_no_count", bus.disp_bcd, 24'h0);
    $display("txn reset mid-run: disp=%h", bus.disp_bcd);

    do_reset(); press(0); tick(10);
    bus.ena = 1'b0; tick(3); press(0);
    check_val("t6_hold_disp", bus.disp_bcd, 24'h000010);
    check_val("t6_hold_running", bus.running, 1'b1);
    bus.ena = 1'b1; cycles(4);
    check_val("t6_ss_dropped", bus.running, 1'b1);
    tick(1);
    check_val("t6_fresh_tick", bus.disp_bcd, 24'h000011);
    press(0);
    check_val("t6_repress", bus.running, 1'b0);
    $display("txn enable hold: disp=%h", bus.disp_bcd);

    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 500; i++) begin
        res     = ($urandom_range(0, 599) == 0);
        bus.ena = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 1) == 1) bus.tick_in = ~bus.tick_in;
        if ($urandom_range(0, 11) == 0) bus.btn_ss  = ~bus.btn_ss;
        if ($urandom_range(0, 11) == 0) bus.btn_lap = ~bus.btn_lap;
        if ($urandom_range(0, 11) == 0) bus.btn_clr = ~bus.btn_clr;
        cycle();
      end
      $display("txn random block %0d: disp=%h running=%0b lap=%0b", blk, bus.disp_bcd,
               bus.running, bus.lap_active);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
